tt_um_serial_sub: RTL and testbench

TT_UM_SERIAL_SUB -- requirements
Module: tt_um_serial_sub

---
 rtl/tt_serial_pkg.sv | 27 ++
 rtl/tt_um_serial_sub_if.sv | 12 +
 rtl/tt_um_serial_sub_full_sub.sv | 11 +
 rtl/tt_um_serial_sub.sv | 106 ++++++++++
 tb/tb_tt_um_serial_sub.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/tt_serial_pkg.sv
// Shared types and pin map for the bit-serial subtractor tile.
package tt_serial_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ui_in fields
  localparam int UI_A     = 0;
  localparam int UI_B     = 1;
  localparam int UI_VLD   = 2;
  localparam int UI_START = 3;

  // uo_out fields
  localparam int UO_DIFF   = 0;
  localparam int UO_BORROW = 1;
  localparam int UO_VLD    = 2;
  localparam int UO_DONE   = 3;
  localparam int UO_IDX    = 4;
  localparam int UO_IDX_W  = 3;
  localparam int UO_BUSY   = 7;

endpackage

// File: rtl/tt_um_serial_sub_if.sv
// Tile pin bundle: enable plus the dedicated/bidirectional 8-bit buses.
interface tt_um_serial_sub_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input  uo_out, uio_out, uio_oe);
  modport slave  (input  ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_serial_sub_full_sub.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial A-B subtractor, LSB first, with per-bit and per-word outputs.
module tt_um_serial_sub
  import tt_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  tt_um_serial_sub_if.slave io
);
  localparam int CW = $clog2(WIDTH);

  logic             rst_q;
  state_t           state;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic             diff_q;
  logic             vld_q;
  logic [UO_IDX_W-1:0] idx_q;

  logic a, b, in_vld, start, d, bout, last, busy, done;

  assign a      = io.ui_in[UI_A];
  assign b      = io.ui_in[UI_B];
  assign in_vld = io.ui_in[UI_VLD];
  assign start  = io.ui_in[UI_START];
  assign last   = (cnt == CW'(WIDTH - 1));

  wire unused_ok = &{1'b0, io.uio_in, io.ui_in[7:4]};

  full_sub u_fs (
    .a   (a),
    .b   (b),
    .bin (borrow),
    .d   (d),
    .bout(bout)
  );

  // Assert immediately, release on the first clk edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      state  <= ST_IDLE;
      borrow <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      word   <= '0;
      diff_q <= 1'b0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
    end else if (io.ena) begin
      vld_q <= 1'b0;
      if (start) begin
        borrow <= 1'b0;
        cnt    <= '0;
        sr     <= '0;
        state  <= ST_RUN;
      end else begin
        case (state)
          ST_RUN: begin
            if (in_vld) begin
              borrow <= bout;
              diff_q <= d;
              idx_q  <= UO_IDX_W'(cnt);
              vld_q  <= 1'b1;
              sr     <= {d, sr[WIDTH-1:1]};
              if (last) begin
                // Word completes on the same edge that accepts the top bit.
                word  <= {d, sr[WIDTH-1:1]};
                cnt   <= '0;
                state <= ST_DONE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

  always_comb begin
    io.uo_out                      = '0;
    io.uo_out[UO_DIFF]             = diff_q;
    io.uo_out[UO_BORROW]           = borrow;
    io.uo_out[UO_VLD]              = vld_q;
    io.uo_out[UO_DONE]             = done;
    io.uo_out[UO_IDX +: UO_IDX_W]  = idx_q;
    io.uo_out[UO_BUSY]             = busy;
  end

  assign io.uio_out = 8'(word);
  assign io.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Directed bench for tt_um_serial_sub with an arithmetic reference model.
module tb_tt_um_serial_sub;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  tt_um_serial_sub_if io();

  tt_um_serial_sub #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  // Reference: track the operand bits accepted so far and derive outputs arithmetically.
  bit         m_live, m_run, m_done;
  int         m_n, m_av, m_bv;
  logic       e_diff, e_borrow, e_vld;
  logic [2:0] e_idx;
  logic [7:0] e_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live = 0; m_run = 0; m_done = 0; m_n = 0; m_av = 0; m_bv = 0;
      e_diff = 0; e_borrow = 0; e_vld = 0; e_idx = 0; e_word = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (io.ena) begin
      e_vld = 0;
      if (io.ui_in[3]) begin
        m_run = 1; m_done = 0; m_n = 0; m_av = 0; m_bv = 0; e_borrow = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run && io.ui_in[2]) begin
        m_av   = m_av | (int'(io.ui_in[0]) << m_n);
        m_bv   = m_bv | (int'(io.ui_in[1]) << m_n);
        m_n    = m_n + 1;
        e_diff = ((((m_av - m_bv) & ((1 << m_n) - 1)) >> (m_n - 1)) & 1) != 0;
        e_borrow = (m_av < m_bv);
        e_idx  = 3'(m_n - 1);
        e_vld  = 1;
        if (m_n == 8) begin
          e_word = 8'((m_av - m_bv) & 255);
          m_run  = 0;
          m_done = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] stream;
  int         vld_cnt, done_cnt;
  logic       fin_borrow;

  always @(negedge clk) begin
    chk("uo_out", {24'b0, io.uo_out},
        {24'b0, m_run | m_done, e_idx, m_done, e_vld, e_borrow, e_diff});
    chk("uio_out", {24'b0, io.uio_out}, {24'b0, e_word});
    chk("uio_oe", {24'b0, io.uio_oe}, 32'hFF);
    if (io.uo_out[2] === 1'b1) begin
      stream[io.uo_out[6:4]] = io.uo_out[0];
      vld_cnt++;
    end
    if (io.uo_out[3] === 1'b1) begin
      done_cnt++;
      fin_borrow = io.uo_out[1];
    end
  end

  task automatic clr_stats();
    stream = 0; vld_cnt = 0; done_cnt = 0; fin_borrow = 1'bx;
  endtask

  task automatic step(input bit a, input bit b, input bit v, input bit s, input bit en);
    io.ui_in = {4'b0, s, v, b, a};
    io.ena   = en;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] av, input logic [7:0] bv, input int gap);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(av[i], bv[i], 1, 0, 1);
      if (i < 7) idle(gap);
    end
  endtask

  initial begin
    io.ena = 0; io.ui_in = 0; io.uio_in = 8'hA5;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    step(0, 0, 0, 0, 1);

    // 0x35 - 0x12, back-to-back bits
    clr_stats();
    send_frame(8'h35, 8'h12, 0);
    idle(3);
    chk("t1_stream", stream, 8'h23);
    chk("t1_word", io.uio_out, 8'h23);
    chk("t1_borrow", fin_borrow, 1'b0);
    chk("t1_vld_cnt", vld_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);

    // 0x12 - 0x35 with two idle cycles between bits
    clr_stats();
    send_frame(8'h12, 8'h35, 2);
    idle(3);
    chk("t2_stream", stream, 8'hDD);
    chk("t2_word", io.uio_out, 8'hDD);
    chk("t2_borrow", fin_borrow, 1'b1);
    chk("t2_vld_cnt", vld_cnt, 8);

    // restart after 4 bits, then 0xFF - 0x01
    clr_stats();
    step(0, 0, 0, 1, 1);
    repeat (4) step(1, 0, 1, 0, 1);
    send_frame(8'hFF, 8'h01, 0);
    idle(3);
    chk("t3_word", io.uio_out, 8'hFE);
    chk("t3_borrow", fin_borrow, 1'b0);
    chk("t3_done_cnt", done_cnt, 1);

    // reset after 5 bits
    clr_stats();
    step(0, 0, 0, 1, 1);
    repeat (5) step(1, 1, 1, 0, 1);
    #1 rst_n = 0;
    #1;
    chk("t4_uo_rst", io.uo_out, 8'h00);
    chk("t4_uio_rst", io.uio_out, 8'h00);
    @(posedge clk);
    #3 rst_n = 1;
    step(0, 0, 0, 1, 1);
    chk("t4_busy_after_edge1", io.uo_out[7], 1'b0);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_uio_after", io.uio_out, 8'h00);

    // start with in_valid in the same cycle: that bit is dropped
    clr_stats();
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(((8'h5A >> i) & 1) != 0, ((8'h3C >> i) & 1) != 0, 1, 0, 1);
    idle(3);
    chk("t6_stream", stream, 8'h1E);
    chk("t6_word", io.uio_out, 8'h1E);
    chk("t6_done_cnt", done_cnt, 1);

    // ena low for 3 cycles mid-frame with in_valid high: 0x80 - 0x80
    clr_stats();
    step(0, 0, 0, 1, 1);
    repeat (4) step(0, 0, 1, 0, 1);
    repeat (3) step(1, 0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 1);
    step(1, 1, 1, 0, 1);
    idle(3);
    chk("t5_stream", stream, 8'h00);
    chk("t5_word", io.uio_out, 8'h00);
    chk("t5_borrow", fin_borrow, 1'b0);
    chk("t5_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
